// File: rtl/mac_stream_feeder_if.sv
// Upstream operand stream into the MAC feeder: one beat carries a column of A
// and a row of B.
interface mac_stream_feeder_if #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH_A-1:0]   in_a;
    logic [2*WIDTH_B-1:0]   in_b;

    modport master (output in_valid, in_a, in_b, input in_ready);
    modport slave  (input in_valid, in_a, in_b, output in_ready);
endinterface

// File: rtl/mac_stream_feeder.sv
// Feeds one 2x2 systolic MAC tile: clears the accumulator, skews operands,
// flushes the array and waits for accumulator_done.
// Optional stall counter: define MAC_FEEDER_STALL_CNT_EN.
module mac_stream_feeder #(
    parameter int WIDTH_A         = 16,
    parameter int FRAC_WIDTH_A    = 8,
    parameter int WIDTH_B         = 16,
    parameter int FRAC_WIDTH_B    = 8,
    parameter int BLOCK_SIZE      = 2,
    parameter int INNER_DIMENSION = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    mac_stream_feeder_if.slave   up,
    input  logic                 acc_done,
    output logic                 mac_en,
    output logic                 acc_rst_n,
    output logic [WIDTH_B-1:0]   in_north0,
    output logic [WIDTH_B-1:0]   in_north1,
    output logic [WIDTH_A-1:0]   in_west0,
    output logic [WIDTH_A-1:0]   in_west2,
    output logic                 busy,
    output logic                 tile_done,
    output logic [15:0]          stall_cycles
);
    localparam int CNT_W     = $clog2(INNER_DIMENSION);
    localparam int FLUSH_CYC = 2*BLOCK_SIZE - 1;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(INNER_DIMENSION - 1);
    localparam logic [1:0]       LAST_FLUSH = 2'(FLUSH_CYC - 1);

    if (BLOCK_SIZE != 2 || INNER_DIMENSION < 2) begin : g_bad_geometry
        $error("mac_stream_feeder: BLOCK_SIZE must be 2 and INNER_DIMENSION >= 2");
    end
    if (FRAC_WIDTH_A > WIDTH_A || FRAC_WIDTH_B > WIDTH_B) begin : g_bad_frac
        $error("mac_stream_feeder: fraction width exceeds operand width");
    end

    typedef enum logic [2:0] {IDLE, CLR, FEED, FLUSH, WAIT_ACC} state_t;

    state_t               state;
    logic [CNT_W-1:0]     beat_cnt;
    logic [1:0]           flush_cnt;
    logic                 done_flag;
    logic [WIDTH_A-1:0]   skew_a;
    logic [WIDTH_B-1:0]   skew_b;

    assign up.in_ready = (state == FEED);
    assign busy        = (state != IDLE);
    // Combinational so a start arriving alongside tile_done still sees WAIT_ACC.
    assign tile_done   = (state == WAIT_ACC) && (acc_done || done_flag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            done_flag <= 1'b0;
            skew_a    <= '0;
            skew_b    <= '0;
            mac_en    <= 1'b0;
            acc_rst_n <= 1'b1;
            in_north0 <= '0;
            in_north1 <= '0;
            in_west0  <= '0;
            in_west2  <= '0;
        end else begin
            mac_en    <= 1'b0;
            acc_rst_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLR;
                        acc_rst_n <= 1'b0;
                    end
                end
                CLR: begin
                    state     <= FEED;
                    beat_cnt  <= '0;
                    flush_cnt <= '0;
                    done_flag <= 1'b0;
                    skew_a    <= '0;
                    skew_b    <= '0;
                end
                FEED: begin
                    // Stalled cycles leave every operand lane untouched so the array freezes.
                    if (up.in_valid) begin
                        mac_en    <= 1'b1;
                        in_north0 <= up.in_b[WIDTH_B-1:0];
                        in_west0  <= up.in_a[WIDTH_A-1:0];
                        in_north1 <= skew_b;
                        in_west2  <= skew_a;
                        skew_b    <= up.in_b[2*WIDTH_B-1:WIDTH_B];
                        skew_a    <= up.in_a[2*WIDTH_A-1:WIDTH_A];
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= FLUSH;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    mac_en    <= 1'b1;
                    in_north0 <= '0;
                    in_west0  <= '0;
                    in_north1 <= skew_b;
                    in_west2  <= skew_a;
                    skew_b    <= '0;
                    skew_a    <= '0;
                    if (acc_done) done_flag <= 1'b1;
                    if (flush_cnt == LAST_FLUSH) begin
                        flush_cnt <= '0;
                        state     <= WAIT_ACC;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                WAIT_ACC: begin
                    if (acc_done || done_flag) begin
                        state     <= IDLE;
                        done_flag <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAC_FEEDER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if (state == CLR)
            stall_q <= '0;
        else if (state == FEED && !up.in_valid && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mac_stream_feeder.sv
// Self-checking bench for mac_stream_feeder: tile-level model built from the
// accepted beat list, per-cycle compare, plus directed literal checks.
module tb_mac_stream_feeder;
    localparam int WA = 16;
    localparam int WB = 16;
    localparam int N  = 4;
    localparam int PH_IDLE = 0, PH_CLR = 1, PH_FEED = 2, PH_FLUSH = 3, PH_WAIT = 4;
`ifdef MAC_FEEDER_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, acc_done = 1'b0;
    logic mac_en, acc_rst_n, busy, tile_done;
    logic [WB-1:0] in_north0, in_north1;
    logic [WA-1:0] in_west0, in_west2;
    logic [15:0]   stall_cycles;

    mac_stream_feeder_if #(.WIDTH_A(WA), .WIDTH_B(WB)) up ();

    mac_stream_feeder #(
        .WIDTH_A(WA), .FRAC_WIDTH_A(8), .WIDTH_B(WB), .FRAC_WIDTH_B(8),
        .BLOCK_SIZE(2), .INNER_DIMENSION(N)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .up(up), .acc_done(acc_done),
        .mac_en(mac_en), .acc_rst_n(acc_rst_n),
        .in_north0(in_north0), .in_north1(in_north1),
        .in_west0(in_west0), .in_west2(in_west2),
        .busy(busy), .tile_done(tile_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // ---------------- behavioural model ----------------
    int phase = PH_IDLE, step = 0, stall_m = 0;
    bit sticky = 1'b0;
    logic [15:0] a0q[$], a1q[$], b0q[$], b1q[$];
    logic        exp_en = 1'b0, exp_arst = 1'b1;
    logic [15:0] exp_n0 = '0, exp_n1 = '0, exp_w0 = '0, exp_w2 = '0;

    // Observations used by the directed literal checks
    logic [15:0] n0_log[$], n1_log[$];
    int tiles_dut = 0, accepts = 0, arst_low_cnt = 0;

    // Array step j: new-data lanes carry beat j, skew lanes carry beat j-1.
    function automatic void model_step(input int j);
        exp_n0 = (j < b0q.size()) ? b0q[j] : 16'h0;
        exp_w0 = (j < a0q.size()) ? a0q[j] : 16'h0;
        exp_n1 = (j >= 1 && j - 1 < b1q.size()) ? b1q[j-1] : 16'h0;
        exp_w2 = (j >= 1 && j - 1 < a1q.size()) ? a1q[j-1] : 16'h0;
    endfunction

    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            chk("rst_mac_en", mac_en, 0);
            chk("rst_acc_rst_n", acc_rst_n, 1);
            chk("rst_busy", busy, 0);
            chk("rst_tile_done", tile_done, 0);
            chk("rst_in_ready", up.in_ready, 0);
            chk("rst_operands", {in_north0, in_north1} | {in_west0, in_west2}, 0);
            chk("rst_stall", stall_cycles, 0);
            phase = PH_IDLE; step = 0; stall_m = 0; sticky = 1'b0;
            exp_en = 1'b0; exp_arst = 1'b1;
            exp_n0 = '0; exp_n1 = '0; exp_w0 = '0; exp_w2 = '0;
        end else begin
            chk("mac_en", mac_en, exp_en);
            chk("acc_rst_n", acc_rst_n, exp_arst);
            chk("in_north0", in_north0, exp_n0);
            chk("in_north1", in_north1, exp_n1);
            chk("in_west0", in_west0, exp_w0);
            chk("in_west2", in_west2, exp_w2);
            chk("busy", busy, phase != PH_IDLE);
            chk("in_ready", up.in_ready, phase == PH_FEED);
            chk("tile_done", tile_done, phase == PH_WAIT && (acc_done || sticky));
            chk("stall_cycles", stall_cycles, STALL_EN ? stall_m : 0);

            if (mac_en === 1'b1) begin
                n0_log.push_back(in_north0);
                n1_log.push_back(in_north1);
            end
            if (tile_done === 1'b1) tiles_dut++;
            if (acc_rst_n === 1'b0) arst_low_cnt++;
            if (up.in_valid === 1'b1 && up.in_ready === 1'b1) accepts++;

            exp_en = 1'b0;
            exp_arst = 1'b1;
            case (phase)
                PH_IDLE: if (start) begin phase = PH_CLR; exp_arst = 1'b0; end
                PH_CLR: begin
                    phase = PH_FEED; step = 0; sticky = 1'b0; stall_m = 0;
                    a0q.delete(); a1q.delete(); b0q.delete(); b1q.delete();
                end
                PH_FEED: begin
                    if (up.in_valid) begin
                        a0q.push_back(up.in_a[15:0]);  a1q.push_back(up.in_a[31:16]);
                        b0q.push_back(up.in_b[15:0]);  b1q.push_back(up.in_b[31:16]);
                        model_step(step); step++; exp_en = 1'b1;
                        if (a0q.size() == N) phase = PH_FLUSH;
                    end else if (stall_m < 65535) begin
                        stall_m++;
                    end
                end
                PH_FLUSH: begin
                    model_step(step); step++; exp_en = 1'b1;
                    if (acc_done) sticky = 1'b1;
                    if (step == N + 3) phase = PH_WAIT;
                end
                PH_WAIT: if (acc_done || sticky) begin phase = PH_IDLE; sticky = 1'b0; end
                default: phase = PH_IDLE;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start();
        @(negedge clk); start = 1'b1; acc_done = 1'b0;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic feed(input bit rnd, input int stall_at, input int stall_len,
                        input int abort_at, input bit start_noise);
        int k = 0, gap = 0, budget = 0;
        while (k < N) begin
            @(negedge clk);
            if (abort_at >= 0 && k == abort_at) begin
                #2 rst_n = 1'b0;
                up.in_valid = 1'b0; start = 1'b0; acc_done = 1'b0;
                return;
            end
            start = start_noise && (k == 1);
            acc_done = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
            if (stall_at == k && gap < stall_len) begin
                up.in_valid = 1'b0;
                gap++;
            end else begin
                up.in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (rnd) begin
                up.in_a = $urandom;
                up.in_b = $urandom;
            end else begin
                up.in_a = {16'(k + 5), 16'(k + 1)};
                up.in_b = {16'(k + 13), 16'(k + 9)};
            end
            if (up.in_valid && up.in_ready) k++;
            if (++budget > 200) begin
                fail_now("feed_timeout");
                return;
            end
        end
    endtask

    task automatic finish(input bit early, input bit b2b, input bit rnd, output int wait_iter);
        int d;
        @(negedge clk); up.in_valid = 1'b0; start = 1'b0;
        acc_done = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
        @(negedge clk); acc_done = early ? 1'b1 : (rnd ? ($urandom_range(0, 7) == 0) : 1'b0);
        @(negedge clk); acc_done = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
        d = rnd ? int'($urandom_range(0, 3)) : 1;
        wait_iter = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            acc_done = (i >= d) && !early;
            start = b2b;
            #1;
            if (tile_done) begin
                wait_iter = i;
                break;
            end
        end
        if (wait_iter < 0) fail_now("tile_done_timeout");
        @(negedge clk); acc_done = 1'b0; start = b2b;
        if (b2b) begin
            @(negedge clk); start = 1'b0;
        end
    endtask

    task automatic check_dir_logs(input string tag, input int base);
        logic [15:0] e0 [7];
        logic [15:0] e1 [7];
        e0 = '{16'd9, 16'd10, 16'd11, 16'd12, 16'd0, 16'd0, 16'd0};
        e1 = '{16'd0, 16'd13, 16'd14, 16'd15, 16'd16, 16'd0, 16'd0};
        chk({tag, "_en_cycles"}, n0_log.size() - base, 7);
        for (int i = 0; i < 7; i++) begin
            if (base + i < n0_log.size()) begin
                chk({tag, "_north0_seq"}, n0_log[base+i], e0[i]);
                chk({tag, "_north1_seq"}, n1_log[base+i], e1[i]);
            end
        end
    endtask

    initial begin
        int t0, c0, a0, w;
        up.in_valid = 1'b0; up.in_a = '0; up.in_b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed single tile
        n0_log.delete(); n1_log.delete();
        t0 = tiles_dut; c0 = arst_low_cnt;
        do_start(); feed(0, -1, 0, -1, 0); finish(0, 0, 0, w);
        check_dir_logs("t1", 0);
        chk("t1_clr_cycles", arst_low_cnt - c0, 1);
        chk("t1_tiles", tiles_dut - t0, 1);

        // Two-cycle stall after beat 1
        n0_log.delete(); n1_log.delete();
        do_start(); feed(0, 2, 2, -1, 0); finish(0, 0, 0, w);
        check_dir_logs("t2", 0);
        chk("t2_stall_cycles", stall_cycles, STALL_EN ? 2 : 0);

        // acc_done during second flush cycle
        t0 = tiles_dut;
        do_start(); feed(0, -1, 0, -1, 0); finish(1, 0, 0, w);
        chk("t3_wait_iter", w, 0);
        chk("t3_tiles", tiles_dut - t0, 1);

        // start while in FEED is ignored
        n0_log.delete(); n1_log.delete();
        t0 = tiles_dut; a0 = accepts;
        do_start(); feed(0, -1, 0, -1, 1); finish(0, 0, 0, w);
        repeat (4) @(negedge clk);
        chk("t4_tiles", tiles_dut - t0, 1);
        chk("t4_beats", accepts - a0, 4);
        chk("t4_en_cycles", n0_log.size(), 7);

        // Async reset mid-FEED, then a clean tile
        t0 = tiles_dut;
        do_start(); feed(0, -1, 0, 2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_no_tile_done", tiles_dut - t0, 0);
        n0_log.delete(); n1_log.delete();
        do_start(); feed(0, -1, 0, -1, 0); finish(0, 0, 0, w);
        check_dir_logs("t5", 0);

        // Back-to-back: start with tile_done ignored, start one cycle later taken
        n0_log.delete(); n1_log.delete();
        t0 = tiles_dut; c0 = arst_low_cnt;
        do_start(); feed(0, -1, 0, -1, 0); finish(0, 1, 0, w);
        feed(0, -1, 0, -1, 0); finish(0, 0, 0, w);
        chk("t6_tiles", tiles_dut - t0, 2);
        chk("t6_clr_cycles", arst_low_cnt - c0, 2);
        check_dir_logs("t6", 7);

        // Randomized tiles
        for (int t = 0; t < 20; t++) begin
            do_start();
            feed(1, -1, 0, -1, $urandom_range(0, 1));
            finish($urandom_range(0, 1), 0, 1, w);
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
